// File: rtl/track_mixer.sv
// track_mixer: gain-weighted, mute-masked, saturating mix of CHANNELS tracks; defining TRACK_MIXER_CLIP_COUNT_EN adds the clip_count output
module track_mixer #(
  parameter int WORD_WIDTH = 16,
  parameter int CHANNELS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sample_tick,
  output logic mix_req,
  output logic mrd,
  input  logic [CHANNELS*WORD_WIDTH-1:0] mdin,
  input  logic [CHANNELS-1:0] mute,
  input  logic gain_wr,
  input  logic [$clog2(CHANNELS)-1:0] gain_ch,
  input  logic [7:0] gain_val,
  output logic [WORD_WIDTH-1:0] mix_out,
  output logic mix_valid,
  output logic overrun
`ifdef TRACK_MIXER_CLIP_COUNT_EN
  , output logic [15:0] clip_count
`endif
);
  localparam int CW = $clog2(CHANNELS);
  localparam int AW = WORD_WIDTH + 2 + CW;
  localparam logic signed [AW-1:0] SMAX = {{(AW-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d, term, sum;
  logic signed [WORD_WIDTH+8:0] prod;
  logic signed [WORD_WIDTH-1:0] smp_q [CHANNELS];
  logic signed [WORD_WIDTH-1:0] smp_d [CHANNELS];
  logic [7:0] gs_q [CHANNELS];
  logic [7:0] gs_d [CHANNELS];
  logic [7:0] gain_q [CHANNELS];
  logic [7:0] gain_d [CHANNELS];
  logic [WORD_WIDTH-1:0] mix_out_q, mix_out_d;
  logic overrun_q, overrun_d, clip, last;
  assign prod = smp_q[cnt_q] * $signed({1'b0, gs_q[cnt_q]});
  assign term = AW'(prod >>> 7);
  assign sum = acc_q + term;
  assign clip = sum > SMAX || sum < SMIN;
  assign last = cnt_q == CW'(CHANNELS - 1);
  assign mix_req = enable;
  assign mrd = state_q == REQ;
  assign mix_valid = state_q == OUT;
  assign mix_out = mix_out_q;
  assign overrun = overrun_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    smp_d = smp_q;
    gs_d = gs_q;
    gain_d = gain_q;
    mix_out_d = mix_out_q;
    overrun_d = sample_tick && state_q != IDLE;
    if (gain_wr) gain_d[gain_ch] = gain_val;
    case (state_q)
      IDLE: state_d = enable && sample_tick ? REQ : IDLE;
      REQ: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ACC;
          cnt_d = '0;
          acc_d = '0;
          for (int i = 0; i < CHANNELS; i++) begin
            smp_d[i] = mute[i] ? '0 : mdin[i*WORD_WIDTH +: WORD_WIDTH];
            gs_d[i] = gain_q[i];
          end
        end
      end
      ACC: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = OUT;
          mix_out_d = clip ? (sum[AW-1] ? SMIN[WORD_WIDTH-1:0] : SMAX[WORD_WIDTH-1:0]) : sum[WORD_WIDTH-1:0];
        end
      end
      OUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!enable && state_q != IDLE) begin
      state_d = IDLE;
      mix_out_d = mix_out_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      smp_q <= '{default: '0};
      gs_q <= '{default: 8'd128};
      gain_q <= '{default: 8'd128};
      mix_out_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      smp_q <= smp_d;
      gs_q <= gs_d;
      gain_q <= gain_d;
      mix_out_q <= mix_out_d;
      overrun_q <= overrun_d;
    end
  end
`ifdef TRACK_MIXER_CLIP_COUNT_EN
  logic clip_q, clip_d;
  logic [15:0] clip_count_q, clip_count_d;
  always_comb begin
    clip_d = state_q == ACC && last ? clip : clip_q;
    clip_count_d = state_q == OUT && clip_q && clip_count_q != 16'hffff ? clip_count_q + 16'd1 : clip_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= 1'b0;
      clip_count_q <= '0;
    end else begin
      clip_q <= clip_d;
      clip_count_q <= clip_count_d;
    end
  end
  assign clip_count = clip_count_q;
`endif
endmodule

// File: tb/tb_track_mixer.sv
// tb_track_mixer: directed and randomized mixes checked against a floor-division gain/mute/saturation reference model
module tb_track_mixer;
  logic clk = 1'b0;
  logic rst, enable, sample_tick, mix_req, mrd, gain_wr, mix_valid, overrun;
  logic [127:0] mdin;
  logic [7:0] mute;
  logic [2:0] gain_ch;
  logic [7:0] gain_val;
  logic [15:0] mix_out;
  int tests = 0;
  int fails = 0;
  int smp [8];
  int gain_m [8];
  always #5 clk = ~clk;
  track_mixer dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
    .mix_req(mix_req), .mrd(mrd), .mdin(mdin), .mute(mute),
    .gain_wr(gain_wr), .gain_ch(gain_ch), .gain_val(gain_val),
    .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun)
  );
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int floor128(input int p);
    return p >= 0 ? p / 128 : -((-p + 127) / 128);
  endfunction
  function automatic int ref_mix(input int g [8]);
    int s = 0;
    for (int i = 0; i < 8; i++) if (!mute[i]) s += floor128(smp[i] * g[i]);
    return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
  endfunction
  task automatic drive_data();
    for (int i = 0; i < 8; i++) mdin[i*16 +: 16] = 16'(smp[i]);
  endtask
  task automatic write_gain(input int ch, input int v);
    gain_wr = 1'b1;
    gain_ch = 3'(ch);
    gain_val = 8'(v);
    @(negedge clk);
    gain_wr = 1'b0;
    gain_m[ch] = v;
  endtask
  task automatic run_mix(input string tag, input int wr_k, input int wr_ch, input int wr_v,
                         input int drop_k, input int tick2_k, input int rst_k);
    int g [8];
    int exp_mix, prev;
    int vcnt = 0, vat = -1, mcnt = 0, mat = -1, ocnt = 0, oat = -1, out_v = 0;
    bit aborted;
    prev = $signed(mix_out);
    g = gain_m;
    if (wr_k >= 0 && wr_k <= 2) g[wr_ch] = wr_v;
    exp_mix = ref_mix(g);
    aborted = drop_k >= 0 || rst_k >= 0;
    drive_data();
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (mix_valid) begin
          vcnt++;
          if (vat < 0) begin
            vat = k;
            out_v = $signed(mix_out);
          end
        end
        if (mrd) begin
          mcnt++;
          if (mat < 0) mat = k;
        end
        if (overrun) begin
          ocnt++;
          if (oat < 0) oat = k;
        end
        if (k == rst_k + 1) begin
          chk({tag, "_rst_mix_out"}, $signed(mix_out), 0);
          chk({tag, "_rst_valid"}, int'(mix_valid), 0);
          chk({tag, "_rst_mrd"}, int'(mrd), 0);
          chk({tag, "_rst_overrun"}, int'(overrun), 0);
        end
      end
      sample_tick = k == 0 || k == tick2_k;
      gain_wr = k == wr_k;
      gain_ch = 3'(wr_ch);
      gain_val = 8'(wr_v);
      enable = !(drop_k >= 0 && k >= drop_k);
      rst = k == rst_k;
    end
    sample_tick = 1'b0;
    gain_wr = 1'b0;
    rst = 1'b0;
    enable = 1'b1;
    if (wr_k >= 0) gain_m[wr_ch] = wr_v;
    if (rst_k >= 0) gain_m = '{default: 128};
    chk({tag, "_mrd_cycles"}, mcnt, 1);
    chk({tag, "_mrd_at"}, mat, 1);
    chk({tag, "_valid_cnt"}, vcnt, aborted ? 0 : 1);
    if (!aborted) begin
      chk({tag, "_valid_at"}, vat, 12);
      chk({tag, "_mix_out"}, out_v, exp_mix);
    end
    chk({tag, "_hold"}, $signed(mix_out), aborted ? (rst_k >= 0 ? 0 : prev) : exp_mix);
    chk({tag, "_overrun_cnt"}, ocnt, tick2_k > 0 ? 1 : 0);
    if (tick2_k > 0) chk({tag, "_overrun_at"}, oat, tick2_k + 1);
  endtask
  initial begin
    rst = 1'b1;
    enable = 1'b1;
    sample_tick = 1'b0;
    gain_wr = 1'b0;
    gain_ch = '0;
    gain_val = '0;
    mute = '0;
    mdin = '0;
    gain_m = '{default: 128};
    repeat (3) @(negedge clk);
    chk("reset_mix_out", $signed(mix_out), 0);
    chk("reset_valid", int'(mix_valid), 0);
    chk("reset_mrd", int'(mrd), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    #1 chk("mix_req_off", int'(mix_req), 0);
    enable = 1'b1;
    #1 chk("mix_req_on", int'(mix_req), 1);
    @(negedge clk);
    smp = '{default: 1000};
    run_mix("unity_1000", -1, 0, 0, -1, -1, -1);
    chk("unity_1000_lit", $signed(mix_out), 8000);
    smp = '{default: 16000};
    run_mix("sat_pos", -1, 0, 0, -1, -1, -1);
    chk("sat_pos_lit", $signed(mix_out), 32767);
    smp = '{default: -16000};
    run_mix("sat_neg", -1, 0, 0, -1, -1, -1);
    chk("sat_neg_lit", $signed(mix_out), -32768);
    write_gain(0, 64);
    write_gain(1, 255);
    mute = 8'hfc;
    smp = '{default: 1000};
    run_mix("gain_mute", -1, 0, 0, -1, -1, -1);
    chk("gain_mute_lit", $signed(mix_out), 2492);
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < 8; c++) write_gain(c, int'($urandom_range(0, 255)));
      for (int c = 0; c < 8; c++) smp[c] = int'($urandom_range(0, 65535)) - 32768;
      mute = 8'($urandom_range(0, 255));
      run_mix("random", -1, 0, 0, -1, -1, -1);
    end
    mute = '0;
    for (int c = 0; c < 8; c++) smp[c] = int'($urandom_range(0, 8191)) - 4096;
    run_mix("overrun", -1, 0, 0, -1, 5, -1);
    run_mix("drop_acc", -1, 0, 0, 6, -1, -1);
    run_mix("after_drop", -1, 0, 0, -1, -1, -1);
    smp[3] = 12000;
    run_mix("wr_in_acc", 6, 3, 17, -1, -1, -1);
    run_mix("wr_next", -1, 0, 0, -1, -1, -1);
    run_mix("wr_with_tick", 0, 5, 200, -1, -1, -1);
    run_mix("rst_in_wait", -1, 0, 0, -1, -1, 2);
    smp = '{default: 1000};
    run_mix("post_rst", -1, 0, 0, -1, -1, -1);
    chk("post_rst_unity_lit", $signed(mix_out), 8000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/track_mixer.md
TRACK_MIXER -- requirements
Module: track_mixer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter CHANNELS, default 8, number of mixed tracks (power of two, 2..16).
REQ-003 SHALL have ports:
- clk  in  1  system clock, 100 MHz; one clock domain, all logic on posedge clk.
- rst  in  1  reset, synchronous and active-high.
- enable  in  1  mixing on; drives mix_req.
- sample_tick  in  1  one-cycle strobe, one per output sample period.
- mix_req  out  1  request to track loader to stream mix data.
- mrd  out  1  read strobe to track loader.
- mdin  in  CHANNELS*WORD_WIDTH  per-channel samples, channel i at bits [i*WORD_WIDTH +: WORD_WIDTH]; valid 2 cycles after mrd rises.
- mute  in  CHANNELS  per-channel mute mask, 1 = excluded from sum.
- gain_wr  in  1  gain table write strobe.
- gain_ch  in  clog2(CHANNELS)  gain table write index.
- gain_val  in  8  unsigned gain, Q1.7 (128 = unity).
- mix_out  out  WORD_WIDTH  mixed, saturated sample.
- mix_valid  out  1  one-cycle pulse, mix_out valid.
- overrun  out  1  one-cycle pulse, sample_tick dropped.

Function
REQ-004 SHALL assign mix_req = enable combinationally.
REQ-005 SHALL implement FSM states IDLE, REQ, WAIT, ACC, OUT.
REQ-006 IDLE: if enable && sample_tick -> REQ next cycle; else stay.
REQ-007 REQ: mrd=1 for exactly this one cycle; -> WAIT; mrd SHALL be 0 in all other states.
REQ-008 WAIT: SHALL last exactly 2 cycles; capture mdin into an internal register at the end of the second WAIT cycle; -> ACC.
REQ-009 ACC: SHALL process one channel per cycle, index 0..CHANNELS-1, CHANNELS cycles total; -> OUT.
REQ-010 per channel: term = (sample * signed{1'b0,gain}) >>> 7 (arithmetic); term = 0 if mute[i] at time of capture.
REQ-011 accumulator SHALL be WORD_WIDTH+2+clog2(CHANNELS) bits signed, cleared on entry to ACC; no internal overflow possible.
REQ-012 OUT: mix_out = accumulator saturated to [-2^(WORD_WIDTH-1), 2^(WORD_WIDTH-1)-1]; mix_valid=1 this cycle; -> IDLE.
REQ-013 latency: sample_tick at cycle T -> mix_valid at cycle T+4+CHANNELS (T+12 for CHANNELS=8).
REQ-014 mix_out SHALL hold its value until the next OUT state.
REQ-015 sample_tick while state != IDLE SHALL be dropped and overrun pulsed high the following cycle; FSM unaffected.
REQ-016 enable low in any non-IDLE state SHALL abort to IDLE next cycle; no mix_valid; mix_out unchanged.
REQ-017 gain_wr SHALL update gain[gain_ch] next cycle; a write during ACC SHALL take effect from the next sample only (gains snapshotted with mdin).
REQ-018 gain_wr and sample_tick in the same cycle SHALL both be honoured.

Reset
REQ-019 on rst: state=IDLE, mrd=0, mix_valid=0, overrun=0, mix_out=0, accumulator=0, all gains=128.
REQ-020 rst mid-operation SHALL discard the sample in progress with no mix_valid.

Configuration
REQ-021 macro TRACK_MIXER_CLIP_COUNT_EN defined: add output clip_count (16 bits), incremented on every OUT where saturation occurred, saturating at 65535, cleared by rst.
REQ-022 macro undefined: no clip_count port, no counter logic; all other behaviour identical.

Verification
REQ-023 CHANNELS=8, gains 128, no mute, all mdin=1000, tick -> mix_valid 12 cycles later, mix_out=8000, mrd high exactly 1 cycle.
REQ-024 all mdin=16000, gains 128 -> mix_out=32767; all mdin=-16000 -> -32768; clip_count increments by 1 each (with macro).
REQ-025 gain[0]=64, gain[1]=255, mdin[0]=1000, mdin[1]=1000, others muted -> mix_out=500+1992=2492.
REQ-026 second tick 5 cycles after first -> overrun pulse 1 cycle later; single mix_valid at T+12.
REQ-027 enable dropped during ACC -> no mix_valid, FSM in IDLE next cycle, mix_out unchanged; next tick after re-enable mixes normally.
REQ-028 rst asserted in WAIT -> all outputs 0, gains back to 128 (verify via next mix at unity).
